// File: rtl/reg_bank_sb.sv
// Register bank with per-register pending-write scoreboard and same-cycle WB-to-ID bypass.
// Produces the ID stall request and a sticky error for retirements with no pending write.
module reg_bank_sb #(
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic [DATA_W-1:0] dado_lido1,
  output logic [DATA_W-1:0] dado_lido2,
  input  logic              issue_valid,
  input  logic              issue_regWrite,
  input  logic [4:0]        issue_rd,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_dado,
  output logic              stall,
  output logic              sb_err
);

  localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

  logic [DATA_W-1:0] regs_q [32];
  logic [1:0]        pend_q [32];
  logic [1:0]        pend_d [32];
  logic [1:0]        eff    [32];
  logic              sb_err_q, sb_err_d;
  logic              retire, accept;
  logic              busy1, busy2, rd_full;
  logic              inc, dec;

  assign retire = wb_regWrite && (wb_rd != 5'd0);

  // A retiring write is bypassed this cycle, so it no longer counts as pending.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      eff[r] = pend_q[r];
      if (retire && (wb_rd == 5'(r)) && (pend_q[r] != 2'd0))
        eff[r] = pend_q[r] - 2'd1;
    end
  end

  assign busy1   = (rs1 != 5'd0) && (eff[rs1] != 2'd0);
  assign busy2   = (rs2 != 5'd0) && (eff[rs2] != 2'd0);
  assign rd_full = issue_regWrite && (issue_rd != 5'd0) && (eff[issue_rd] == PEND_MAX);
  assign stall   = issue_valid && (busy1 || busy2 || rd_full);
  assign accept  = issue_valid && issue_regWrite && !stall && (issue_rd != 5'd0);

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < 32; r++) begin
      inc       = accept && (issue_rd == 5'(r));
      dec       = retire && (wb_rd == 5'(r)) && (pend_q[r] != 2'd0);
      pend_d[r] = pend_q[r];
      if (inc && !dec)
        pend_d[r] = pend_q[r] + 2'd1;
      else if (dec && !inc)
        pend_d[r] = pend_q[r] - 2'd1;
    end
  end

  assign sb_err_d = sb_err_q || (retire && (pend_q[wb_rd] == 2'd0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++)
        pend_q[r] <= pend_d[r];
      sb_err_q <= sb_err_d;
      if (retire)
        regs_q[wb_rd] <= wb_dado;
    end
  end

  // Reads are forced to zero while reset is held so bypass cannot leak through.
  always_comb begin
    if (!reset_n || (rs1 == 5'd0))
      dado_lido1 = '0;
    else if (wb_regWrite && (wb_rd == rs1))
      dado_lido1 = wb_dado;
    else
      dado_lido1 = regs_q[rs1];

    if (!reset_n || (rs2 == 5'd0))
      dado_lido2 = '0;
    else if (wb_regWrite && (wb_rd == rs2))
      dado_lido2 = wb_dado;
    else
      dado_lido2 = regs_q[rs2];
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: the driver pushes expectations from a list-of-in-flight-writes
// model, and a monitor pops and compares them against the DUT outputs.
module tb_reg_bank_sb;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [4:0]    rs1, rs2, issue_rd, wb_rd;
  logic [DW-1:0] dado_lido1, dado_lido2, wb_dado;
  logic          issue_valid, issue_regWrite, wb_regWrite;
  logic          stall, sb_err;

  always #5 clock = ~clock;

  reg_bank_sb #(.DATA_W(DW), .MAX_PEND(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .rs1(rs1), .rs2(rs2),
    .dado_lido1(dado_lido1), .dado_lido2(dado_lido2),
    .issue_valid(issue_valid), .issue_regWrite(issue_regWrite), .issue_rd(issue_rd),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_dado(wb_dado),
    .stall(stall), .sb_err(sb_err)
  );

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          st;
    logic          er;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  logic [DW-1:0] m_regs[32];
  int            inflight[$];
  bit            m_err;

  function automatic int pend_of(int r);
    int c = 0;
    foreach (inflight[i]) if (inflight[i] == r) c++;
    return c;
  endfunction

  function automatic int eff_of(int r, bit ww, int wrd);
    int c = pend_of(r);
    if (ww && wrd == r && r != 0 && c > 0) c--;
    return c;
  endfunction

  function automatic logic [DW-1:0] rd_model(int rs, bit ww, int wrd, logic [DW-1:0] wd);
    if (rs == 0) return '0;
    if (ww && wrd == rs) return wd;
    return m_regs[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    inflight.delete();
    m_err = 1'b0;
  endtask

  task automatic cycle(input bit iv, input bit iw, input int ird, input int r1, input int r2,
                       input bit ww, input int wrd, input logic [DW-1:0] wd);
    exp_t e;
    bit   st;
    int   idx;
    @(negedge clock);
    reset_n        = 1'b1;
    issue_valid    = iv;
    issue_regWrite = iw;
    issue_rd       = 5'(ird);
    rs1            = 5'(r1);
    rs2            = 5'(r2);
    wb_regWrite    = ww;
    wb_rd          = 5'(wrd);
    wb_dado        = wd;
    st = iv && ((r1 != 0 && eff_of(r1, ww, wrd) > 0) ||
                (r2 != 0 && eff_of(r2, ww, wrd) > 0) ||
                (iw && ird != 0 && eff_of(ird, ww, wrd) == 3));
    e.d1 = rd_model(r1, ww, wrd, wd);
    e.d2 = rd_model(r2, ww, wrd, wd);
    e.st = st;
    e.er = m_err;
    exp_q.push_back(e);
    if (ww && wrd != 0) begin
      m_regs[wrd] = wd;
      idx = -1;
      for (int i = 0; i < inflight.size(); i++)
        if (idx < 0 && inflight[i] == wrd) idx = i;
      if (idx >= 0) inflight.delete(idx);
      else m_err = 1'b1;
    end
    if (iv && iw && !st && ird != 0) inflight.push_back(ird);
  endtask

  // Reset asserted mid-cycle; outputs are checked before any clock edge arrives.
  task automatic do_reset(input int r1, input int r2);
    exp_t e;
    @(negedge clock);
    reset_n        = 1'b0;
    issue_valid    = 1'b1;
    issue_regWrite = 1'b1;
    issue_rd       = 5'(r1);
    rs1            = 5'(r1);
    rs2            = 5'(r2);
    wb_regWrite    = 1'b0;
    wb_rd          = 5'd0;
    wb_dado        = '0;
    model_clear();
    e.d1 = '0;
    e.d2 = '0;
    e.st = 1'b0;
    e.er = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (dado_lido1 !== e.d1) begin
          n_err++;
          $display("FAIL dado_lido1 vec %0d: got %h want %h", n_vec, dado_lido1, e.d1);
        end
        if (dado_lido2 !== e.d2) begin
          n_err++;
          $display("FAIL dado_lido2 vec %0d: got %h want %h", n_vec, dado_lido2, e.d2);
        end
        if (stall !== e.st) begin
          n_err++;
          $display("FAIL stall vec %0d: got %b want %b", n_vec, stall, e.st);
        end
        if (sb_err !== e.er) begin
          n_err++;
          $display("FAIL sb_err vec %0d: got %b want %b", n_vec, sb_err, e.er);
        end
      end
    end
  end

  initial begin : driver
    bit            iv, iw, ww;
    int            ird, r1, r2, wrd, k;
    logic [DW-1:0] wd;
    issue_valid = 0; issue_regWrite = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    wb_regWrite = 0; wb_rd = 0; wb_dado = 0;
    model_clear();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    do_reset(5, 0);

    // write r5, read it, then reset mid-sequence
    cycle(1, 1, 5, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5, 32'hDEAD);
    cycle(0, 0, 0, 5, 0, 0, 0, 0);
    do_reset(5, 5);
    cycle(0, 0, 0, 5, 5, 0, 0, 0);

    // write then read, and r0 ignores writes
    cycle(1, 1, 3, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3, 32'h1234);
    cycle(0, 0, 0, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
    cycle(0, 0, 0, 0, 3, 0, 0, 0);

    // same-cycle bypass
    cycle(1, 1, 7, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 7, 32'h1);
    cycle(1, 1, 7, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 7, 1, 7, 32'h99);
    cycle(0, 0, 0, 0, 7, 0, 0, 0);

    // RAW stall until producer retires
    cycle(1, 1, 4, 0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 4, 0, 0, 0, 0);
    cycle(1, 0, 0, 4, 0, 1, 4, 32'hABCD);
    cycle(1, 0, 0, 0, 4, 0, 0, 0);

    // saturation at three in-flight writes
    repeat (3) cycle(1, 1, 9, 0, 0, 0, 0, 0);
    cycle(1, 1, 9, 0, 0, 0, 0, 0);
    cycle(1, 1, 9, 0, 0, 1, 9, 32'h5);
    cycle(1, 1, 9, 0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 9, 0, 1, 9, 32'h6);
    cycle(1, 1, 9, 9, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 9, 32'h7);

    // retirement with nothing pending
    cycle(0, 0, 0, 12, 0, 1, 12, 32'h77);
    cycle(1, 1, 12, 12, 0, 0, 0, 0);
    cycle(0, 0, 0, 12, 0, 1, 12, 32'h78);
    cycle(0, 0, 0, 12, 0, 0, 0, 0);
    do_reset(12, 9);
    cycle(0, 0, 0, 12, 9, 0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 7), $urandom_range(0, 7));
      iv  = ($urandom_range(0, 3) != 0);
      iw  = $urandom_range(0, 1);
      ird = $urandom_range(0, 7);
      r1  = $urandom_range(0, 7);
      r2  = $urandom_range(0, 7);
      ww  = 0;
      wrd = 0;
      wd  = $urandom;
      k   = $urandom_range(0, 9);
      if (inflight.size() > 0 && k < 5) begin
        ww  = 1;
        wrd = inflight[$urandom_range(0, inflight.size() - 1)];
      end else if (k == 5) begin
        ww = 1;
      end else if (k == 6 && $urandom_range(0, 9) == 0) begin
        ww  = 1;
        wrd = $urandom_range(1, 7);
      end
      cycle(iv, iw, ird, r1, r2, ww, wrd, wd);
    end

    repeat (3) @(negedge clock);
    #4;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
